vga_fetch_ctrl: RTL

- AXI-side scheduler that keeps the VGA ping/pong line buffer filled.
- Issues 32-beat INCR read bursts that walk from base_addr_i toward top_addr_i and wrap at the end.
- Tracks which bank (ping=0, pong=1) is free, emits per-beat bank write strobes, and stalls fetching while both banks are full.
- Sits between the config unit, the AXI read channels and the buffer storage.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_bank_tracker.sv | 60 ++++++
 rtl/vga_fetch_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA line-buffer fetch path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vga_pkg;

    // Fetch scheduler states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADDR     = 2'd1,
        ST_DATA     = 2'd2,
        ST_WAIT_BUF = 2'd3
    } fetch_state_e;

    // One burst fills exactly one bank
    localparam int BURST_LEN   = 32;
    localparam int BEAT_BYTES  = 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;

    // AXI read-address encodings
    localparam logic [7:0] ARLEN_FIXED  = 8'(BURST_LEN - 1);
    localparam logic [1:0] ARBURST_INCR = 2'h1;
    localparam logic [2:0] ARSIZE_8B    = 3'h3;
    localparam logic [1:0] RESP_OKAY    = 2'h0;

    // Beat counter value of the final beat of a burst
    localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);

endpackage

// File: rtl/vga_bank_tracker.sv
// Ping/pong occupancy: full flags, fill pointer, read pointer, release/complete merge.
// Latency: flags update on the clock after init/complete/release; next_fill_full_o is combinational look-ahead.
// Backpressure: none; a release of an empty read bank is dropped silently.
module vga_bank_tracker
    import vga_pkg::*;
(
    input  logic clk_a,
    input  logic resetn_a,
    input  logic init_i,
    input  logic complete_i,
    input  logic release_i,
    output logic fill_bank_o,
    output logic fill_full_o,
    output logic next_fill_full_o
);

    logic [1:0] full_q, full_d;
    logic       fill_q, fill_d;
    logic       read_q, read_d;

    // Merge burst completion and reader release; both may land in one cycle
    always_comb begin
        full_d = full_q;
        fill_d = fill_q;
        read_d = read_q;
        if (init_i) begin
            full_d = 2'b00;
            fill_d = 1'b0;
            read_d = 1'b0;
        end else begin
            if (complete_i) begin
                full_d[fill_q] = 1'b1;
                fill_d         = ~fill_q;
            end
            // Release of a bank that was never filled is an underrun: ignore it
            if (release_i && full_q[read_q]) begin
                full_d[read_q] = 1'b0;
                read_d         = ~read_q;
            end
        end
        next_fill_full_o = full_d[fill_d];
    end

    // Occupancy state registers
    always_ff @(posedge clk_a or negedge resetn_a) begin
        if (!resetn_a) begin
            full_q <= 2'b00;
            fill_q <= 1'b0;
            read_q <= 1'b0;
        end else begin
            full_q <= full_d;
            fill_q <= fill_d;
            read_q <= read_d;
        end
    end

    assign fill_bank_o = fill_q;
    assign fill_full_o = full_q[fill_q];

endmodule

// File: rtl/vga_fetch_ctrl.sv
// AXI read scheduler keeping the VGA ping/pong line buffer full with 32-beat INCR bursts.
// Latency: AR issues the cycle after entering ADDR; each R beat reaches the bank write port 1 cycle later.
// Backpressure: AR held until arready_i; rready_o always high in DATA; fetching stalls while both banks are full.
module vga_fetch_ctrl
    import vga_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_a,
    input  logic                  resetn_a,
    input  logic                  enable_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] top_addr_i,
    input  logic                  buf_release_i,
    input  logic                  arready_i,
    output logic                  arvalid_o,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [7:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    input  logic                  rvalid_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  rready_o,
    output logic                  wr_en_o,
    output logic                  wr_bank_o,
    output logic [4:0]            wr_idx_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  frame_start_o,
    output logic                  err_o
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [4:0]            beat_q, beat_d;
    logic                  ar_fixed_q, ar_fixed_d;
    logic                  wr_en_q, wr_en_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [4:0]            wr_idx_q, wr_idx_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  frame_start_q, frame_start_d;
    logic                  err_q, err_d;

    logic                  trk_init;
    logic                  burst_done;
    logic                  fill_bank;
    logic                  fill_full;
    logic                  next_fill_full;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  is_last;

    // Tracker strobes are decoded from registered state only, so the
    // look-ahead full flag can feed next-state logic without a comb loop.
    assign trk_init   = (state_q == ST_IDLE) && enable_i;
    assign is_last    = (beat_q == LAST_BEAT);
    assign burst_done = (state_q == ST_DATA) && rvalid_i && is_last;
    assign next_addr  = addr_q + ADDR_WIDTH'(BURST_BYTES);

    vga_bank_tracker u_bank_tracker (
        .clk_a            (clk_a),
        .resetn_a         (resetn_a),
        .init_i           (trk_init),
        .complete_i       (burst_done),
        .release_i        (buf_release_i),
        .fill_bank_o      (fill_bank),
        .fill_full_o      (fill_full),
        .next_fill_full_o (next_fill_full)
    );

    // Next-state, address walk, beat capture and error detection
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        ar_fixed_d    = ar_fixed_q;
        wr_en_d       = 1'b0;
        wr_bank_d     = wr_bank_q;
        wr_idx_d      = wr_idx_q;
        wr_data_d     = wr_data_q;
        frame_start_d = 1'b0;
        err_d         = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    addr_d     = base_addr_i;
                    beat_d     = 5'd0;
                    ar_fixed_d = 1'b1;
                    state_d    = ST_ADDR;
                end
            end

            ST_ADDR: begin
                // A handshake in the same cycle as disable still commits the burst
                if (arready_i) begin
                    addr_d        = (next_addr >= top_addr_i) ? base_addr_i : next_addr;
                    frame_start_d = (addr_q == base_addr_i);
                    state_d       = ST_DATA;
                end else if (!enable_i) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DATA: begin
                if (rvalid_i) begin
                    wr_en_d   = 1'b1;
                    wr_bank_d = fill_bank;
                    wr_idx_d  = beat_q;
                    wr_data_d = rdata_i;
                    beat_d    = beat_q + 5'd1;
                    if (rresp_i != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    if (rlast_i != is_last) begin
                        err_d = 1'b1;
                    end
                    // Disable only takes effect once the full burst is drained
                    if (is_last) begin
                        beat_d = 5'd0;
                        if (!enable_i) begin
                            state_d = ST_IDLE;
                        end else if (next_fill_full) begin
                            state_d = ST_WAIT_BUF;
                        end else begin
                            state_d = ST_ADDR;
                        end
                    end
                end
            end

            ST_WAIT_BUF: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (!fill_full) begin
                    state_d = ST_ADDR;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers; reset abandons any burst in flight
    always_ff @(posedge clk_a or negedge resetn_a) begin
        if (!resetn_a) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            beat_q        <= 5'd0;
            ar_fixed_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_bank_q     <= 1'b0;
            wr_idx_q      <= 5'd0;
            wr_data_q     <= '0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            beat_q        <= beat_d;
            ar_fixed_q    <= ar_fixed_d;
            wr_en_q       <= wr_en_d;
            wr_bank_q     <= wr_bank_d;
            wr_idx_q      <= wr_idx_d;
            wr_data_q     <= wr_data_d;
            frame_start_q <= frame_start_d;
            err_q         <= err_d;
        end
    end

    assign arvalid_o     = (state_q == ST_ADDR);
    assign araddr_o      = addr_q;
    assign arlen_o       = ar_fixed_q ? ARLEN_FIXED  : 8'h00;
    assign arsize_o      = ar_fixed_q ? ARSIZE_8B    : 3'h0;
    assign arburst_o     = ar_fixed_q ? ARBURST_INCR : 2'h0;
    assign rready_o      = (state_q == ST_DATA);
    assign wr_en_o       = wr_en_q;
    assign wr_bank_o     = wr_bank_q;
    assign wr_idx_o      = wr_idx_q;
    assign wr_data_o     = wr_data_q;
    assign frame_start_o = frame_start_q;
    assign err_o         = err_q;

endmodule
